td4_datapath: RTL and testbench

- Execution datapath of the TD4 4-bit CPU, directly downstream of the instruction decoder.
- Consumes the decoder's active-low LOAD[3:0], SELECTA and SELECTB, plus the immediate field of the current instruction.
- Holds the architectural state: registers A and B, the output latch, the program counter and the carry flag.
- Returns the carry flag to the decoder and returns the PC to instruction fetch.

---
 rtl/td4_datapath.sv | 94 +++++++++
 tb/tb_td4_datapath.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/td4_datapath.sv
// td4_datapath
// Execution datapath of the TD4 4-bit CPU. Sits directly behind the
// instruction decoder and holds all architectural state: registers A and B,
// the output-port latch, the program counter and the carry flag.
//
// Ports
//   CLK      in   system clock, all state updates on the rising edge
//   RESET    in   synchronous active-high reset, wins over everything
//   CE       in   clock enable; every register holds while low
//   Im       in   immediate field of the current instruction
//   IN       in   external input port
//   LOAD     in   active-low load strobes: [0]=A [1]=B [2]=OUT [3]=PC
//   SELECTA  in   source select, low bit
//   SELECTB  in   source select, high bit
//   OUT      out  output-port latch
//   PC       out  program counter (instruction ROM address)
//   Carry    out  registered carry of the previous enabled instruction
//   RegA     out  register A, for observation
//   RegB     out  register B, for observation
//
// There is no handshake: the decoder presents one instruction per enabled
// cycle and its results are visible after the next rising edge.
module td4_datapath #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] Im,
  input  logic [WIDTH-1:0] IN,
  input  logic [3:0]       LOAD,
  input  logic             SELECTA,
  input  logic             SELECTB,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] PC,
  output logic             Carry,
  output logic [WIDTH-1:0] RegA,
  output logic [WIDTH-1:0] RegB
);

  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] reg_out;
  logic [WIDTH-1:0] reg_pc;
  logic             reg_carry;

  logic [WIDTH-1:0] src;
  logic [WIDTH:0]   total;
  logic [WIDTH-1:0] sum;
  logic             co;

  // Source mux; select 11 feeds zero so "mov reg, imm" is just 0 + Im.
  always_comb begin
    src = '0;
    case ({SELECTB, SELECTA})
      2'b00:   src = reg_a;
      2'b01:   src = reg_b;
      2'b10:   src = IN;
      default: src = '0;
    endcase
  end

  // One extra bit holds the carry-out; sum wraps modulo 2^WIDTH.
  assign total = {1'b0, src} + {1'b0, Im};
  assign sum   = total[WIDTH-1:0];
  assign co    = total[WIDTH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      reg_a     <= '0;
      reg_b     <= '0;
      reg_out   <= '0;
      reg_pc    <= '0;
      reg_carry <= 1'b0;
    end else if (CE) begin
      if (!LOAD[0]) reg_a   <= sum;
      if (!LOAD[1]) reg_b   <= sum;
      if (!LOAD[2]) reg_out <= sum;
      // A jump replaces the increment; otherwise PC free-runs and wraps.
      if (!LOAD[3]) reg_pc  <= sum;
      else          reg_pc  <= reg_pc + WIDTH'(1);
      // Carry follows every enabled addition, so any non-overflowing
      // instruction clears it.
      reg_carry <= co;
    end
  end

  assign OUT   = reg_out;
  assign PC    = reg_pc;
  assign Carry = reg_carry;
  assign RegA  = reg_a;
  assign RegB  = reg_b;

endmodule

// File: tb/tb_td4_datapath.sv
module tb_td4_datapath;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RESET;
  logic       CE;
  logic [3:0] Im;
  logic [3:0] IN;
  logic [3:0] LOAD;
  logic       SELECTA;
  logic       SELECTB;
  logic [3:0] OUT;
  logic [3:0] PC;
  logic       Carry;
  logic [3:0] RegA;
  logic [3:0] RegB;

  always #5 CLK = ~CLK;

  td4_datapath #(.WIDTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .Im(Im), .IN(IN), .LOAD(LOAD),
    .SELECTA(SELECTA), .SELECTB(SELECTB), .OUT(OUT), .PC(PC),
    .Carry(Carry), .RegA(RegA), .RegB(RegB)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model: plain integers updated by the instruction rules.
  int m_a, m_b, m_out, m_pc, m_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_a"},     32'(RegA),  32'(m_a));
    check({tag, "_b"},     32'(RegB),  32'(m_b));
    check({tag, "_out"},   32'(OUT),   32'(m_out));
    check({tag, "_pc"},    32'(PC),    32'(m_pc));
    check({tag, "_carry"}, 32'(Carry), 32'(m_c));
  endtask

  // ---------------- driver tasks ----------------
  // One instruction: drive at negedge, model it on the posedge, sample #1 later.
  task automatic step(input string tag, input logic ce, input logic [3:0] ld,
                      input int sel, input int im, input int inp);
    int src, total, s;
    @(negedge CLK);
    RESET = 1'b0; CE = ce; LOAD = ld;
    {SELECTB, SELECTA} = 2'(sel);
    Im = 4'(im); IN = 4'(inp);
    @(posedge CLK);
    if (ce) begin
      case (sel & 3)
        0:       src = m_a;
        1:       src = m_b;
        2:       src = inp & 15;
        default: src = 0;
      endcase
      total = src + (im & 15);
      s     = total % 16;
      if (!ld[0]) m_a   = s;
      if (!ld[1]) m_b   = s;
      if (!ld[2]) m_out = s;
      m_pc = ld[3] ? (m_pc + 1) % 16 : s;
      m_c  = (total > 15) ? 1 : 0;
    end
    #1;
    check_all(tag);
  endtask

  // Reset edge(s) with random other inputs; reset must override all of them.
  task automatic do_reset(input string tag, input int cycles, input bit force_ce0);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      RESET = 1'b1;
      CE    = force_ce0 ? 1'b0 : 1'($urandom_range(0, 1));
      LOAD  = 4'($urandom_range(0, 15));
      Im    = 4'($urandom_range(0, 15));
      IN    = 4'($urandom_range(0, 15));
      {SELECTB, SELECTA} = 2'($urandom_range(0, 3));
      @(posedge CLK);
      m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0;
      #1;
      check_all(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1; CE = 1'b0; LOAD = 4'hF; Im = '0; IN = '0;
    SELECTA = 1'b0; SELECTB = 1'b0;
    m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0;

    // Reset, then a free-running step.
    do_reset("reset", 2, 1'b0);
    step("post_reset", 1'b1, 4'b1111, 3, 0, 0);
    check("pc_after_reset", 32'(PC), 32'd1);

    // Immediate and add with carry.
    step("mov_a5", 1'b1, 4'b1110, 3, 5, 0);
    check("mov_a5_const", 32'(RegA), 32'd5);
    step("add_a12", 1'b1, 4'b1110, 0, 12, 0);
    check("add_a12_const", 32'(RegA), 32'd1);
    check("add_a12_carry", 32'(Carry), 32'd1);
    step("nop_clears_c", 1'b1, 4'b1111, 3, 0, 0);
    check("carry_cleared", 32'(Carry), 32'd0);

    // Transfers and I/O.
    step("mov_a3", 1'b1, 4'b1110, 3, 3, 9);
    step("mov_b_b", 1'b1, 4'b1101, 1, 0, 9);
    check("b_from_b", 32'(RegB), 32'd0);
    step("out_in", 1'b1, 4'b1011, 2, 2, 9);
    check("out_in_plus2", 32'(OUT), 32'd11);
    step("mov_b_a", 1'b1, 4'b1101, 0, 1, 9);
    check("b_from_a", 32'(RegB), 32'd4);

    // PC increment, wrap and jump.
    do_reset("reset_pc", 1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step("pc_run", 1'b1, 4'b1111, 3, 0, 0);
      check("pc_step", 32'(PC), 32'((i + 1) % 16));
    end
    step("jmp7", 1'b1, 4'b0111, 3, 7, 0);
    check("jmp7_const", 32'(PC), 32'd7);
    step("after_jmp", 1'b1, 4'b1111, 3, 0, 0);
    check("after_jmp_const", 32'(PC), 32'd8);

    // CE gating: nothing moves while disabled.
    step("mov_a6", 1'b1, 4'b1110, 3, 6, 0);
    for (int i = 0; i < 3; i++) step("ce_off", 1'b0, 4'b0000, 0, 1, 0);
    step("ce_on", 1'b1, 4'b0000, 0, 1, 0);
    check("ce_on_a",   32'(RegA), 32'd7);
    check("ce_on_b",   32'(RegB), 32'd7);
    check("ce_on_out", 32'(OUT),  32'd7);
    check("ce_on_pc",  32'(PC),   32'd7);

    // Reset mid-run with CE low.
    step("mov_a15", 1'b1, 4'b1110, 3, 15, 0);
    step("jmp_carry", 1'b1, 4'b0111, 0, 11, 0);
    check("pre_reset_pc", 32'(PC), 32'd10);
    check("pre_reset_c",  32'(Carry), 32'd1);
    check("pre_reset_a",  32'(RegA), 32'd15);
    do_reset("reset_ce0", 1, 1'b1);

    // Randomized instruction stream against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0)
        do_reset("rand_reset", 1, 1'b0);
      else
        step("rand", 1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)));
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
